mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Load/store unit of the CPU memory stage. It accepts one load or store per request from the execute stage and runs a req/ack transaction on the data bus. For stores it generates byte-lane strobes and replicates write data. For loads it extracts and sign- or zero-extends the returned data, which feeds the load-data input of the writeback select multiplexor. It stalls the pipeline while a transaction is outstanding and flags misaligned, illegal, errored or timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 255, number of cycles I_bus_ack may stay low while O_bus_req is high before the access is aborted as a fault (1..255)

Ports:
I_clk  input  1  clock; all state updates on the rising edge
I_rst_n  input  1  asynchronous active-low reset
I_req  input  1  execute stage presents a memory access this cycle
I_we  input  1  1 = store, 0 = load
I_funct3  input  3  RISC-V width/sign field: 000 B, 001 H, 010 W, 100 BU, 101 HU
I_addr  input  32  byte address
I_wdata  input  32  store data; the low byte or halfword is used for B/H
O_busy  output  1  pipeline stall request
O_rdata  output  32  extended load result
O_rvalid  output  1  one-cycle pulse: O_rdata updated by a completed load
O_fault  output  1  one-cycle pulse: access rejected or aborted
O_bus_req  output  1  bus request, held until ack
O_bus_we  output  1  bus write enable
O_bus_addr  output  32  word-aligned address {addr[31:2],2'b00}
O_bus_be  output  4  byte enables
O_bus_wdata  output  32  lane-replicated store data
I_bus_ack  input  1  bus completes the transfer this cycle
I_bus_err  input  1  qualifies I_bus_ack; the transfer failed
I_bus_rdata  input  32  read word, valid with I_bus_ack

Behaviour:
- Reset (async, I_rst_n=0): state IDLE. O_rdata=0. O_rvalid=0. O_fault=0. O_bus_req=0, O_bus_we=0, O_bus_addr=0, O_bus_be=0, O_bus_wdata=0. Timeout counter=0. A reset asserted mid-transaction drops O_bus_req immediately, without waiting for a clock edge.
- States: IDLE, BUS.
- IDLE + I_req:
  - Legality check: funct3 110/111 is illegal. Alignment: H/HU requires addr[0]=0; W requires addr[1:0]=00.
  - Illegal or misaligned: O_fault=1 on the next cycle, no bus activity, state stays IDLE.
  - Legal: latch we, funct3, addr[1:0] and the bus fields; go to BUS. O_bus_req=1 from the next cycle.
- O_busy (combinational) = (state==BUS) | (state==IDLE & I_req & legal). The request cycle itself stalls.
- BUS:
  - O_bus_req, O_bus_we, O_bus_addr, O_bus_be and O_bus_wdata stay stable until the cycle in which I_bus_ack=1.
  - The counter increments each cycle without ack. If the counter reaches TIMEOUT_CYCLES, go to IDLE with O_bus_req=0 and pulse O_fault.
  - Ack with I_bus_err=1: go to IDLE, pulse O_fault, leave O_rdata unchanged.
  - Ack with no error on a load: capture the extracted value into O_rdata, pulse O_rvalid next cycle, go to IDLE.
  - Ack with no error on a store: go to IDLE; no O_rvalid pulse.
  - I_req is ignored while in BUS.
- Minimum latency: request at cycle T, O_bus_req at T+1, ack at T+1, O_rvalid and O_busy=0 at T+2. A new request can be accepted at T+2.
- Store lanes (addr[1:0]=a):
  - B: be = 0001<<a, wdata = {4{byte}}.
  - H: be = a[1] ? 1100 : 0011, wdata = {2{half}}.
  - W: be = 1111, wdata unchanged.
- Load extraction:
  - B/BU select byte lane a; H/HU select halfword lane a[1].
  - B and H sign-extend; BU and HU zero-extend; W passes the word through.
  - Loads drive O_bus_be=1111.
- O_rdata holds its value between loads.
- O_rvalid and O_fault are never high in the same cycle.

Test Plan:
- LB at 0x103, bus_rdata 0x80FF1234, ack on the first BUS cycle -> bus_addr 0x100, be 1111; O_rdata 0xFFFFFF80 with O_rvalid at T+2. The same access as LBU -> 0x00000080.
- LH at 0x102 with rdata 0x80FF1234 -> O_rdata 0xFFFF80FF. LHU at 0x100 -> 0x00001234.
- SB at 0x201, I_wdata 0x000000AB, ack delayed 3 cycles -> bus_addr 0x200, be 0010, bus_wdata 0xABABABAB, all held stable for 4 cycles; O_busy high throughout; no O_rvalid.
- LW at 0x102, and a separate access with funct3=110 -> O_fault pulse, O_bus_req never asserted, O_busy low.
- TIMEOUT_CYCLES=8, no ack -> O_bus_req high for 8 cycles, then O_fault pulse, O_bus_req=0, state IDLE. In a second run, ack with I_bus_err=1 -> O_fault, O_rdata unchanged.
- I_rst_n low for 1 cycle mid-BUS -> O_bus_req=0 immediately. After release, a fresh LW at 0x10 with rdata 0xDEADBEEF -> O_rdata 0xDEADBEEF.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit for the memory stage: one req/ack bus transaction per accepted access,
// with store lane steering, load extension, stall generation and fault reporting.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_req,
    input  logic        I_we,
    input  logic [2:0]  I_funct3,
    input  logic [31:0] I_addr,
    input  logic [31:0] I_wdata,
    output logic        O_busy,
    output logic [31:0] O_rdata,
    output logic        O_rvalid,
    output logic        O_fault,
    output logic        O_bus_req,
    output logic        O_bus_we,
    output logic [31:0] O_bus_addr,
    output logic [3:0]  O_bus_be,
    output logic [31:0] O_bus_wdata,
    input  logic        I_bus_ack,
    input  logic        I_bus_err,
    input  logic [31:0] I_bus_rdata
);

    // state | meaning
    // IDLE  | waiting for a request from execute
    // BUS   | bus request outstanding, waiting for ack or timeout
    typedef enum logic {IDLE, BUS} state_t;

    localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        lat_we;
    logic [2:0]  lat_f3;
    logic [1:0]  lat_lo;
    logic        legal;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    // 011 (doubleword) has no meaning on a 32-bit bus, so it is rejected with 110/111
    always_comb begin
        legal = 1'b0;
        case (I_funct3)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = ~I_addr[0];
            3'b010:         legal = (I_addr[1:0] == 2'b00);
            default:        legal = 1'b0;
        endcase
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = I_wdata;
        if (I_we) begin
            case (I_funct3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << I_addr[1:0];
                    st_wdata = {4{I_wdata[7:0]}};
                end
                2'b01: begin
                    st_be    = I_addr[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{I_wdata[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = I_wdata;
                end
            endcase
        end
    end

    always_comb begin
        case (lat_lo)
            2'b00:   ld_byte = I_bus_rdata[7:0];
            2'b01:   ld_byte = I_bus_rdata[15:8];
            2'b10:   ld_byte = I_bus_rdata[23:16];
            default: ld_byte = I_bus_rdata[31:24];
        endcase
        ld_half = lat_lo[1] ? I_bus_rdata[31:16] : I_bus_rdata[15:0];
        case (lat_f3)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = I_bus_rdata;
        endcase
    end

    assign O_busy = (state == BUS) | ((state == IDLE) & I_req & legal);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            lat_we      <= 1'b0;
            lat_f3      <= 3'd0;
            lat_lo      <= 2'd0;
            O_rdata     <= 32'd0;
            O_rvalid    <= 1'b0;
            O_fault     <= 1'b0;
            O_bus_req   <= 1'b0;
            O_bus_we    <= 1'b0;
            O_bus_addr  <= 32'd0;
            O_bus_be    <= 4'd0;
            O_bus_wdata <= 32'd0;
        end else begin
            O_rvalid <= 1'b0;
            O_fault  <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_req) begin
                        if (legal) begin
                            lat_we      <= I_we;
                            lat_f3      <= I_funct3;
                            lat_lo      <= I_addr[1:0];
                            cnt         <= 8'd0;
                            O_bus_req   <= 1'b1;
                            O_bus_we    <= I_we;
                            O_bus_addr  <= {I_addr[31:2], 2'b00};
                            O_bus_be    <= st_be;
                            O_bus_wdata <= st_wdata;
                            state       <= BUS;
                        end else begin
                            O_fault <= 1'b1;
                        end
                    end
                end
                BUS: begin
                    if (I_bus_ack) begin
                        O_bus_req <= 1'b0;
                        cnt       <= 8'd0;
                        state     <= IDLE;
                        if (I_bus_err) begin
                            O_fault <= 1'b1;
                        end else if (!lat_we) begin
                            O_rdata  <= ld_val;
                            O_rvalid <= 1'b1;
                        end
                    end else if (cnt == TC_LAST) begin
                        O_bus_req <= 1'b0;
                        O_fault   <= 1'b1;
                        cnt       <= 8'd0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, rejects, timeout, bus error
// and mid-transaction reset, all against hand-computed values.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy;
    logic [31:0] rdata;
    logic        rvalid;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    int n_checks = 0;
    int n_pass = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
        .I_clk       (clk),
        .I_rst_n     (rst_n),
        .I_req       (req),
        .I_we        (we),
        .I_funct3    (funct3),
        .I_addr      (addr),
        .I_wdata     (wdata),
        .O_busy      (busy),
        .O_rdata     (rdata),
        .O_rvalid    (rvalid),
        .O_fault     (fault),
        .O_bus_req   (bus_req),
        .O_bus_we    (bus_we),
        .O_bus_addr  (bus_addr),
        .O_bus_be    (bus_be),
        .O_bus_wdata (bus_wdata),
        .I_bus_ack   (bus_ack),
        .I_bus_err   (bus_err),
        .I_bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issue one legal access, hold ack off for 'delay' BUS cycles, then ack.
    // Returns after the cycle following ack has been sampled (rvalid/fault cycle).
    task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int delay,
                          input logic err, input logic [3:0] exp_be, input logic [31:0] exp_wd);
        @(posedge clk); #1;
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        check("busy_req_cycle", 32'(busy), 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        for (int i = 0; i <= delay; i++) begin
            if (i == delay) begin
                bus_ack = 1'b1; bus_err = err; bus_rdata = rd;
            end
            @(negedge clk);
            check("bus_req", 32'(bus_req), 32'd1);
            check("bus_we", 32'(bus_we), 32'(w));
            check("bus_addr", bus_addr, {a[31:2], 2'b00});
            check("bus_be", 32'(bus_be), 32'(exp_be));
            if (w) check("bus_wdata", bus_wdata, exp_wd);
            check("busy_bus", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        bus_ack = 1'b0; bus_err = 1'b0;
        @(negedge clk);
        check("rvalid", 32'(rvalid), 32'(!w && !err));
        check("fault", 32'(fault), 32'(err));
        check("busy_done", 32'(busy), 32'd0);
        check("bus_req_done", 32'(bus_req), 32'd0);
    endtask

    task automatic reject(input logic [2:0] f3, input logic [31:0] a);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; funct3 = f3; addr = a;
        @(negedge clk);
        check("busy_reject", 32'(busy), 32'd0);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        check("fault_reject", 32'(fault), 32'd1);
        check("bus_req_reject", 32'(bus_req), 32'd0);
        check("rvalid_reject", 32'(rvalid), 32'd0);
        @(posedge clk); #1;
        check("fault_one_cycle", 32'(fault), 32'd0);
    endtask

    initial begin
        int req_cycles;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        rst_n = 1'b1;

        access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 1'b0, 4'b1111, 32'h0);
        check("lb", rdata, 32'hFFFFFF80);
        access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 1'b0, 4'b1111, 32'h0);
        check("lbu", rdata, 32'h00000080);
        access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 0, 1'b0, 4'b1111, 32'h0);
        check("lh", rdata, 32'hFFFF80FF);
        access(1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF1234, 0, 1'b0, 4'b1111, 32'h0);
        check("lhu", rdata, 32'h00001234);
        access(1'b0, 3'b000, 32'h101, 32'h0, 32'h80FF1234, 1, 1'b0, 4'b1111, 32'h0);
        check("lb_lane1", rdata, 32'h00000012);

        access(1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 3, 1'b0, 4'b0010, 32'hABABABAB);
        check("sb_rdata_held", rdata, 32'h00000012);
        access(1'b1, 3'b001, 32'h202, 32'h1234CDEF, 32'h0, 0, 1'b0, 4'b1100, 32'hCDEFCDEF);
        access(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 1, 1'b0, 4'b1111, 32'hCAFEF00D);

        reject(3'b010, 32'h102);
        reject(3'b110, 32'h100);
        reject(3'b001, 32'h101);

        // Timeout: no ack at all
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h400;
        @(posedge clk); #1;
        req = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 20 && bus_req; i++) begin
            req_cycles++;
            @(posedge clk); #1;
        end
        check("timeout_req_cycles", 32'(req_cycles), 32'd8);
        check("timeout_fault", 32'(fault), 32'd1);
        check("timeout_bus_req", 32'(bus_req), 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_rdata_held", rdata, 32'h00000012);

        access(1'b0, 3'b010, 32'h500, 32'h0, 32'h55555555, 2, 1'b1, 4'b1111, 32'h0);
        check("err_rdata_held", rdata, 32'h00000012);

        // Reset mid-transaction drops the request without a clock edge
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h600;
        @(posedge clk); #1;
        req = 1'b0;
        check("pre_rst_bus_req", 32'(bus_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_bus_req", 32'(bus_req), 32'd0);
        check("async_rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        access(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1'b0, 4'b1111, 32'h0);
        check("lw_after_rst", rdata, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
